z80_boot_overlay: RTL and testbench

//  Synchronous, parametrised boot-code overlay for the Z80 bus. It replaces the fixed

---
 rtl/z80_boot_overlay_pkg.sv | 17 +
 rtl/z80_boot_overlay_if.sv | 30 +++
 rtl/z80_boot_overlay_spram.sv | 32 +++
 rtl/z80_boot_overlay.sv | 152 +++++++++++++++
 tb/tb_z80_boot_overlay.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/z80_boot_overlay_pkg.sv
// Shared types and constants for the Z80 boot-code overlay: read FSM states,
// control-port bit positions and the default control port number.
package z80_ovl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RDREQ,
        ST_WAIT,
        ST_DRIVE
    } ovl_state_e;

    localparam int CTRL_OFF = 0;
    localparam int CTRL_WP  = 1;

    localparam logic [7:0] CTRL_PORT_DEF = 8'hF7;

endpackage

// File: rtl/z80_boot_overlay_if.sv
// Z80 bus plus host loader stream as seen by the boot overlay.
// The CPU-side read data is called dout because "do" is a reserved word.
interface z80_boot_overlay_if;

    logic [15:0] a;
    logic [7:0]  di;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic [7:0]  dout;
    logic        ovl_hit;
    logic        wait_n;
    logic        ovl_on;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;

    modport master (
        output a, di, mreq_n, iorq_n, rd_n, wr_n, ld_start, ld_valid, ld_data,
        input  dout, ovl_hit, wait_n, ovl_on, ld_ready
    );

    modport slave (
        input  a, di, mreq_n, iorq_n, rd_n, wr_n, ld_start, ld_valid, ld_data,
        output dout, ovl_hit, wait_n, ovl_on, ld_ready
    );

endinterface

// File: rtl/z80_boot_overlay_spram.sv
// Single-port synchronous byte RAM holding the boot image, with a registered
// read port; shaped to map onto block RAM.
module ovl_spram #(
    parameter int    AW       = 8,
    parameter string INIT_HEX = ""
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [2**AW];
    logic [7:0] rdata_q;

    // The output register only updates on a read, so it holds the last read
    // byte for as long as the overlay keeps driving it.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/z80_boot_overlay.sv
// Reloadable boot-code overlay: maps a RAM image into a Z80 memory window,
// stretches reads with WAIT_n, and can be switched off from an I/O port.
module z80_boot_overlay
    import z80_ovl_pkg::*;
#(
    parameter int          AW        = 8,
    parameter logic [15:0] BASE      = 16'h0000,
    parameter int          WAIT_CYC  = 1,
    parameter logic [7:0]  CTRL_PORT = CTRL_PORT_DEF,
    parameter string       INIT_HEX  = ""
) (
    input logic               clk,
    input logic               rst_n,
    z80_boot_overlay_if.slave bus
);

    localparam logic [2:0] WCNT_INIT = (WAIT_CYC > 1) ? 3'(WAIT_CYC - 1) : 3'd0;

    ovl_state_e    state_q;
    logic [2:0]    wcnt_q;
    logic [7:0]    do_q;
    logic          wait_n_q;
    logic          ovl_on_q;
    logic          off_pend_q;
    logic          wp_q;
    logic          ctrl_sel_q;
    logic          rdy_en_q;
    logic [AW-1:0] ld_ptr_q;

    logic          win;
    logic          rd_req;
    logic          rd_issue;
    logic          ld_ready;
    logic          ld_acc;
    logic          ctrl_sel;
    logic          ctrl_hit;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_q;
    logic          unused_di;

    // A pending switch-off already closes the window for new reads.
    assign win      = ovl_on_q & ~off_pend_q & (bus.a[15:AW] == BASE[15:AW]);
    assign rd_req   = ~bus.mreq_n & ~bus.rd_n & win;
    assign rd_issue = (state_q == ST_IDLE) & rd_req;

    assign ld_ready = rdy_en_q & ~wp_q & (state_q == ST_IDLE) & ~rd_req;
    assign ld_acc   = bus.ld_valid & ld_ready & ~bus.ld_start;

    assign ctrl_sel  = ~bus.iorq_n & ~bus.wr_n & (bus.a[7:0] == CTRL_PORT);
    assign ctrl_hit  = ctrl_sel & ~ctrl_sel_q;
    assign unused_di = ^bus.di[7:2];

    assign ram_addr = ld_acc ? ld_ptr_q : bus.a[AW-1:0];

    ovl_spram #(
        .AW      (AW),
        .INIT_HEX(INIT_HEX)
    ) u_ram (
        .clk    (clk),
        .en_i   (rd_issue | ld_acc),
        .we_i   (ld_acc),
        .addr_i (ram_addr),
        .wdata_i(bus.ld_data),
        .rdata_o(ram_q)
    );

    // Read FSM; WAIT_n is low for exactly WAIT_CYC cycles counting RDREQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wcnt_q   <= 3'd0;
            do_q     <= 8'hFF;
            wait_n_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    do_q     <= 8'hFF;
                    wait_n_q <= 1'b1;
                    if (rd_issue) begin
                        state_q  <= ST_RDREQ;
                        wait_n_q <= (WAIT_CYC == 0);
                    end
                end
                ST_RDREQ: begin
                    wcnt_q <= WCNT_INIT;
                    if (WAIT_CYC <= 1) begin
                        state_q  <= ST_DRIVE;
                        do_q     <= ram_q;
                        wait_n_q <= 1'b1;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wcnt_q <= wcnt_q - 3'd1;
                    if (wcnt_q == 3'd1) begin
                        state_q  <= ST_DRIVE;
                        do_q     <= ram_q;
                        wait_n_q <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (bus.mreq_n | bus.rd_n) begin
                        state_q <= ST_IDLE;
                        do_q    <= 8'hFF;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Control port: sticky off and write-protect, applied once per strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovl_on_q   <= 1'b1;
            off_pend_q <= 1'b0;
            wp_q       <= 1'b0;
            ctrl_sel_q <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            rdy_en_q   <= 1'b1;
            ctrl_sel_q <= ctrl_sel;
            if (ctrl_hit && bus.di[CTRL_OFF]) begin
                off_pend_q <= 1'b1;
            end
            if (ctrl_hit && bus.di[CTRL_WP]) begin
                wp_q <= 1'b1;
            end
            if (off_pend_q && (state_q == ST_IDLE)) begin
                ovl_on_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_ptr_q <= '0;
        end else if (bus.ld_start) begin
            ld_ptr_q <= '0;
        end else if (ld_acc) begin
            ld_ptr_q <= ld_ptr_q + 1'b1;
        end
    end

    assign bus.dout     = do_q;
    assign bus.ovl_hit  = rd_issue | (state_q != ST_IDLE);
    assign bus.wait_n   = wait_n_q;
    assign bus.ovl_on   = ovl_on_q;
    assign bus.ld_ready = ld_ready;

endmodule

// File: tb/tb_z80_boot_overlay.sv
// Bench for z80_boot_overlay: three instances (WAIT_CYC 0, 1, 3) share one
// stimulus stream; results are compared against an array model of the image.
module tb_z80_boot_overlay;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a;
    logic [7:0]  di;
    logic        mreq_n, iorq_n, rd_n, wr_n;
    logic        ld_start, ld_valid;
    logic [7:0]  ld_data;

    int checks = 0;
    int failures = 0;

    byte unsigned memModel [256];
    bit           ovlModel;
    int           ptrModel;
    int           loadedCount;

    z80_boot_overlay_if ifc0 ();
    z80_boot_overlay_if ifc1 ();
    z80_boot_overlay_if ifc3 ();

    assign ifc0.a = a;        assign ifc1.a = a;        assign ifc3.a = a;
    assign ifc0.di = di;      assign ifc1.di = di;      assign ifc3.di = di;
    assign ifc0.mreq_n = mreq_n; assign ifc1.mreq_n = mreq_n; assign ifc3.mreq_n = mreq_n;
    assign ifc0.iorq_n = iorq_n; assign ifc1.iorq_n = iorq_n; assign ifc3.iorq_n = iorq_n;
    assign ifc0.rd_n = rd_n;  assign ifc1.rd_n = rd_n;  assign ifc3.rd_n = rd_n;
    assign ifc0.wr_n = wr_n;  assign ifc1.wr_n = wr_n;  assign ifc3.wr_n = wr_n;
    assign ifc0.ld_start = ld_start; assign ifc1.ld_start = ld_start; assign ifc3.ld_start = ld_start;
    assign ifc0.ld_valid = ld_valid; assign ifc1.ld_valid = ld_valid; assign ifc3.ld_valid = ld_valid;
    assign ifc0.ld_data = ld_data;   assign ifc1.ld_data = ld_data;   assign ifc3.ld_data = ld_data;

    z80_boot_overlay #(.AW(8), .BASE(16'h0000), .WAIT_CYC(0), .CTRL_PORT(8'hF7), .INIT_HEX(""))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0));
    z80_boot_overlay #(.AW(8), .BASE(16'h0000), .WAIT_CYC(1), .CTRL_PORT(8'hF7), .INIT_HEX(""))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));
    z80_boot_overlay #(.AW(8), .BASE(16'h0000), .WAIT_CYC(3), .CTRL_PORT(8'hF7), .INIT_HEX(""))
        dut3 (.clk(clk), .rst_n(rst_n), .bus(ifc3));

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired observed=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Holds a memory read for seven cycles, then releases it for one idle cycle.
    task automatic applyRead(input logic [15:0] addr, input bit all);
        logic         expHit;
        byte unsigned expData;
        int           low0 = 0, low1 = 0, low3 = 0;
        bit           hitOk = 1'b1;
        logic [7:0]   d0at2 = 8'h00, d1at2 = 8'h00;
        @(negedge clk);
        a = addr; mreq_n = 1'b0; rd_n = 1'b0;
        #1;
        expHit  = ovlModel && (addr[15:8] == 8'h00);
        expData = expHit ? memModel[addr[7:0]] : 8'hFF;
        checkOutput("hit_comb", 32'(ifc1.ovl_hit), 32'(expHit));
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (!ifc0.wait_n) low0++;
            if (!ifc1.wait_n) low1++;
            if (!ifc3.wait_n) low3++;
            if (ifc1.ovl_hit !== expHit) hitOk = 1'b0;
            if (i == 2) begin
                d0at2 = ifc0.dout;
                d1at2 = ifc1.dout;
            end
        end
        checkOutput("wait_cycles_wc1", 32'(low1), expHit ? 32'd1 : 32'd0);
        checkOutput("hit_hold", 32'(hitOk), 32'd1);
        checkOutput("read_data_wc1", 32'(ifc1.dout), 32'(expData));
        checkOutput("read_data_wc1_clk2", 32'(d1at2), 32'(expData));
        if (all) begin
            checkOutput("wait_cycles_wc0", 32'(low0), 32'd0);
            checkOutput("wait_cycles_wc3", 32'(low3), expHit ? 32'd3 : 32'd0);
            checkOutput("read_data_wc0_clk2", 32'(d0at2), 32'(expData));
            checkOutput("read_data_wc3", 32'(ifc3.dout), 32'(expData));
        end
        mreq_n = 1'b1; rd_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_do", 32'(ifc1.dout), 32'hFF);
        checkOutput("idle_wait", 32'(ifc1.wait_n), 32'd1);
        checkOutput("idle_hit", 32'(ifc1.ovl_hit), 32'd0);
    endtask

    // Streams bytes through the valid/ready handshake; the model records a
    // byte at the write pointer whenever the handshake completes.
    task automatic applyLoad(input int n, input bit rnd, input byte unsigned first);
        byte unsigned b;
        bit           acc;
        int           budget;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            b = rnd ? 8'($urandom) : 8'(first + 8'(i));
            ld_valid = 1'b1;
            ld_data  = b;
            budget   = 0;
            acc      = 1'b0;
            while (!acc && budget <= 50) begin
                #4;
                acc = ifc1.ld_ready;
                if (acc) begin
                    memModel[ptrModel] = b;
                    ptrModel = (ptrModel + 1) % 256;
                    loadedCount++;
                end
                budget++;
                @(negedge clk);
            end
            if (!acc) begin
                checks++;
                failures++;
                $error("[TB] FAIL loader_timeout observed=no_accept required=accept byte=%0d", i);
                break;
            end
        end
        ld_valid = 1'b0;
    endtask

    task automatic applyIoWrite(input logic [7:0] d);
        @(negedge clk);
        a = 16'h00F7; di = d; iorq_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1; a = 16'hFFFF; di = 8'h00;
        if (d[0]) ovlModel = 1'b0;
    endtask

    task automatic resetModel();
        ovlModel = 1'b1;
        ptrModel = 0;
    endtask

    initial begin
        byte unsigned expData;
        int           hi;
        logic [15:0]  addr;

        a = 16'hFFFF; di = 8'h00; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
        loadedCount = 0;
        resetModel();

        repeat (3) @(negedge clk);
        checkOutput("rst_do", 32'(ifc1.dout), 32'hFF);
        checkOutput("rst_hit", 32'(ifc1.ovl_hit), 32'd0);
        checkOutput("rst_wait", 32'(ifc1.wait_n), 32'd1);
        checkOutput("rst_ovl_on", 32'(ifc1.ovl_on), 32'd1);
        checkOutput("rst_ld_ready", 32'(ifc1.ld_ready), 32'd0);
        rst_n = 1'b1;

        $display("[TB] load 0x10..0x1F and read with WAIT_CYC 0/1/3");
        applyLoad(16, 1'b0, 8'h10);
        applyRead(16'h0005, 1'b1);
        applyRead(16'h0000, 1'b1);
        applyRead(16'h000F, 1'b1);
        applyRead(16'h0100, 1'b1);
        applyRead(16'h8003, 1'b1);

        $display("[TB] loader streaming with concurrent CPU reads");
        fork
            applyLoad(300, 1'b1, 8'h00);
            begin
                for (int k = 0; k < 25; k++) begin
                    hi   = (loadedCount >= 256) ? 255 : loadedCount - 1;
                    addr = ($urandom_range(0, 3) == 0) ? 16'(16'h0100 + $urandom_range(0, 16'hFE00))
                                                       : 16'($urandom_range(0, hi));
                    applyRead(addr, 1'b0);
                end
            end
        join
        for (int k = 0; k < 12; k++) applyRead(16'($urandom_range(0, 255)), 1'b0);
        applyRead(16'h0000, 1'b0);
        applyRead(16'h00FF, 1'b0);
        applyLoad(1, 1'b0, 8'hC3);
        applyRead(16'(ptrModel - 1), 1'b0);

        $display("[TB] ld_start together with ld_valid");
        @(negedge clk);
        ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'h5A;
        @(negedge clk);
        ld_start = 1'b0; ld_valid = 1'b0;
        ptrModel = 0;
        applyRead(16'h0000, 1'b0);
        applyLoad(1, 1'b0, 8'hA5);
        applyRead(16'h0000, 1'b0);
        applyRead(16'h0001, 1'b0);

        $display("[TB] control write during DRIVE");
        @(negedge clk);
        a = 16'h0003; mreq_n = 1'b0; rd_n = 1'b0;
        expData = memModel[3];
        repeat (2) @(negedge clk);
        a = 16'h00F7; di = 8'h01; iorq_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1; di = 8'h00;
        ovlModel = 1'b0;
        checkOutput("ctrl_drive_data", 32'(ifc1.dout), 32'(expData));
        checkOutput("ctrl_drive_hit", 32'(ifc1.ovl_hit), 32'd1);
        checkOutput("ctrl_drive_ovl_on", 32'(ifc1.ovl_on), 32'd1);
        mreq_n = 1'b1; rd_n = 1'b1; a = 16'hFFFF;
        repeat (2) @(negedge clk);
        checkOutput("ctrl_ovl_off", 32'(ifc1.ovl_on), 32'd0);
        applyRead(16'h0000, 1'b0);
        applyIoWrite(8'h00);
        checkOutput("ctrl_sticky", 32'(ifc1.ovl_on), 32'd0);
        applyRead(16'h0005, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("ctrl_reset_on", 32'(ifc1.ovl_on), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        resetModel();
        applyRead(16'h0005, 1'b0);

        $display("[TB] write protect");
        applyIoWrite(8'h02);
        ld_valid = 1'b1; ld_data = 8'hEE;
        for (int k = 0; k < 8; k++) begin
            #4;
            checkOutput("wp_ld_ready", 32'(ifc1.ld_ready), 32'd0);
            @(negedge clk);
        end
        ld_valid = 1'b0;
        checkOutput("wp_ovl_on", 32'(ifc1.ovl_on), 32'd1);
        applyRead(16'h0000, 1'b0);
        applyRead(16'h0001, 1'b0);

        $display("[TB] reset in the middle of a read");
        @(negedge clk);
        a = 16'h0002; mreq_n = 1'b0; rd_n = 1'b0;
        @(negedge clk);
        checkOutput("midrd_wait_low", 32'(ifc1.wait_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrd_wait_async", 32'(ifc1.wait_n), 32'd1);
        mreq_n = 1'b1; rd_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        resetModel();
        applyRead(16'h0002, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
